bcd_seq_converter: RTL

Sequential binary-to-BCD converter controller. It sequences an iterative shift-and-add-3 (double-dabble) datapath over DATA_W clock cycles. Input is taken through a valid/ready handshake, and the registered hundreds/tens/ones digits are returned through a second valid/ready handshake. It sits between the arithmetic/input logic and the 7-segment display drivers, replacing the fully combinational add-3 cascade where area and timing matter more than latency.

---
 rtl/bcd_seq_converter_pkg.sv | 23 ++
 rtl/bcd_seq_converter_digit_adj.sv | 21 ++
 rtl/bcd_seq_converter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_seq_converter_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter.
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - BCD field widths and the double-dabble add-3 constants
// Optional build macro honoured by the converter: SIGNED_EN
// ----------------------------------------------------------------------------
package bcd_pkg;

    localparam int DIGIT_W    = 4;   // one BCD digit
    localparam int HUND_W     = 2;   // hundreds digit only reaches 0..2
    localparam int BCD_W      = 10;  // {hundreds, tens, ones}
    localparam int ADJ_THRESH = 5;   // digits at or above this get corrected
    localparam int ADJ_ADD    = 3;   // correction added before the shift
    localparam int CNT_W      = 4;   // bit counter, holds DATA_W up to 8

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_e;

endpackage

// File: rtl/bcd_seq_converter_digit_adj.sv
// ----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble correction cell: a digit of 5 or more gets +3
// so that the following left shift carries correctly into the next decade.
// Ports:
//   digit_in  [3:0] : BCD digit before correction
//   digit_out [3:0] : corrected digit (unchanged when below 5)
// ----------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    // Digits only ever hold 0..9 before correction, so +3 cannot overflow.
    assign digit_out = (digit_in >= DIGIT_W'(ADJ_THRESH))
                     ? digit_in + DIGIT_W'(ADJ_ADD)
                     : digit_in;

endmodule

// File: rtl/bcd_seq_converter.sv
// ----------------------------------------------------------------------------
// bcd_seq_converter
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Optional build macro: SIGNED_EN (treat in_data as two's complement and
// report the sign on out_neg; otherwise out_neg is tied low).
// Parameters:
//   DATA_W       : input width, legal 2..8
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   in_valid     : in_data holds a value to convert
//   in_ready     : converter idle and able to accept
//   in_data      : value to convert
//   out_valid    : result registers hold a fresh result
//   out_ready    : consumer takes the result
//   out_ones     : BCD ones digit
//   out_tens     : BCD tens digit
//   out_hundreds : BCD hundreds digit (0..2)
//   out_neg      : result is negative (SIGNED_EN builds only)
// ----------------------------------------------------------------------------
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DIGIT_W-1:0]   out_ones,
    output logic [DIGIT_W-1:0]   out_tens,
    output logic [HUND_W-1:0]    out_hundreds,
    output logic                 out_neg
);

    // Widths outside 2..8 either break the shift slicing or overflow 255.
    generate
        if ((DATA_W < 2) || (DATA_W > 8)) begin : g_bad_width
            $error("bcd_seq_converter: DATA_W must be in 2..8");
        end
    endgenerate

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_SHIFT = 2'(ST_SHIFT);
    localparam logic [1:0] S_DONE  = 2'(ST_DONE);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]          state_reg;
    logic [DATA_W-1:0]   mag_reg;
    logic [BCD_W-1:0]    scratch_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [DIGIT_W-1:0]  ones_reg;
    logic [DIGIT_W-1:0]  tens_reg;
    logic [HUND_W-1:0]   hund_reg;

    // ------------------------------------------------------------------
    // Input magnitude / sign extraction
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   mag_in;

`ifdef SIGNED_EN
    logic                sign_in;
    logic                sign_reg;
    logic                neg_reg;

    // Negating the most negative value wraps back to itself, which read as
    // unsigned is exactly its magnitude (e.g. 8'h80 -> 128).
    assign sign_in = in_data[DATA_W-1];
    assign mag_in  = sign_in ? (~in_data + DATA_W'(1)) : in_data;
`else
    assign mag_in  = in_data;
`endif

    // ------------------------------------------------------------------
    // Add-3 correction on each scratch digit
    // ------------------------------------------------------------------
    logic [DIGIT_W-1:0]  adj_in  [3];
    logic [DIGIT_W-1:0]  adj_out [3];

    assign adj_in[0] = scratch_reg[3:0];
    assign adj_in[1] = scratch_reg[7:4];
    // Hundreds never exceeds 2 so its cell never fires; it is zero-extended
    // to reuse the same 4-bit cell.
    assign adj_in[2] = {{(DIGIT_W-HUND_W){1'b0}}, scratch_reg[9:8]};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_in  (adj_in[gi]),
                .digit_out (adj_out[gi])
            );
        end
    endgenerate

    logic [BCD_W-1:0]    adj_scratch;
    logic [BCD_W-1:0]    shift_scratch;
    logic [DATA_W-1:0]   shift_mag;

    assign adj_scratch   = {adj_out[2][HUND_W-1:0], adj_out[1], adj_out[0]};
    // {scratch, magnitude} shifted left by one: the magnitude MSB enters
    // the ones digit; the scratch MSB leaving is always zero.
    assign shift_scratch = {adj_scratch[BCD_W-2:0], mag_reg[DATA_W-1]};
    assign shift_mag     = {mag_reg[DATA_W-2:0], 1'b0};

    // Bits that are provably zero for legal widths.
    logic unused_bits;
    assign unused_bits = ^{adj_out[2][DIGIT_W-1:HUND_W], adj_scratch[BCD_W-1]};

    logic last_shift;
    assign last_shift = (cnt_reg == CNT_W'(1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  if (in_valid)   state_reg <= S_SHIFT;
                S_SHIFT: if (last_shift) state_reg <= S_DONE;
                S_DONE:  if (out_ready)  state_reg <= S_IDLE;
                default:                 state_reg <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shift datapath and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_reg     <= '0;
            scratch_reg <= '0;
            cnt_reg     <= '0;
        end else if ((state_reg == S_IDLE) && in_valid) begin
            mag_reg     <= mag_in;
            scratch_reg <= '0;
            cnt_reg     <= CNT_W'(DATA_W);
        end else if (state_reg == S_SHIFT) begin
            mag_reg     <= shift_mag;
            scratch_reg <= shift_scratch;
            cnt_reg     <= cnt_reg - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Result registers: loaded only on the final shift so the scratch
    // never shows through, and held until the next result.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_reg <= '0;
            tens_reg <= '0;
            hund_reg <= '0;
        end else if ((state_reg == S_SHIFT) && last_shift) begin
            ones_reg <= shift_scratch[3:0];
            tens_reg <= shift_scratch[7:4];
            hund_reg <= shift_scratch[9:8];
        end
    end

`ifdef SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_reg <= 1'b0;
            neg_reg  <= 1'b0;
        end else begin
            if ((state_reg == S_IDLE) && in_valid) begin
                sign_reg <= sign_in;
            end
            if ((state_reg == S_SHIFT) && last_shift) begin
                neg_reg <= sign_reg;
            end
        end
    end

    assign out_neg = neg_reg;
`else
    assign out_neg = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs: straight from registers, handshakes decoded from state only
    // ------------------------------------------------------------------
    assign in_ready     = (state_reg == S_IDLE);
    assign out_valid    = (state_reg == S_DONE);
    assign out_ones     = ones_reg;
    assign out_tens     = tens_reg;
    assign out_hundreds = hund_reg;

endmodule
